// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared encodings for the ALU sequential issuer
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } aluOp_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } issState_t;

    localparam int CMD_WIDTH       = 13;
    localparam int CMD_OP_LSB      = 11;
    localparam int CMD_DST_LSB     = 9;
    localparam int CMD_RA_LSB      = 7;
    localparam int CMD_RB_LSB      = 5;
    localparam int CMD_USE_IMM_BIT = 4;
    localparam int CMD_IMM_LSB     = 0;

endpackage

// File: rtl/ALU1.sv
// rtl/ALU1.sv - 4-bit combinational ALU (AND/OR/XOR/ADD)
module ALU1 (
    input  logic [3:0] inA,
    input  logic [3:0] inB,
    input  logic [1:0] op,
    output logic [3:0] ans
);

    // Pure combinational operation select; ADD drops the carry-out.
    always_comb begin
        ans = 4'h0;
        case (op)
            2'b00:   ans = inA & inB;
            2'b01:   ans = inA | inB;
            2'b10:   ans = inA ^ inB;
            default: ans = inA + inB;
        endcase
    end

endmodule

// File: rtl/alu_seq_issuer.sv
// rtl/alu_seq_issuer.sv - command-driven issuer for ALU1; optional res_carry via ALU_SEQ_CARRY_EN
module alu_seq_issuer
    import alu_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CMD_WIDTH-1:0] cmd,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [3:0]           res_data,
    output logic [1:0]           res_dst,
    output logic [7:0]           op_count
`ifdef ALU_SEQ_CARRY_EN
    ,
    output logic                 res_carry
`endif
);

    issState_t       state, nextState;
    logic [3:0][3:0] regFile;
    aluOp_t          capOp;
    logic [1:0]      capDst;
    logic [3:0]      capA, capB;
    logic [3:0]      aluAns;
    logic [1:0]      cmdRa, cmdRb;
    logic [3:0]      opA, opB;
    logic            acceptCmd, retireRes;

    // regFile[0] is never written, so reading index 0 yields zero for free.
    assign cmdRa     = cmd[CMD_RA_LSB +: 2];
    assign cmdRb     = cmd[CMD_RB_LSB +: 2];
    assign opA       = regFile[cmdRa];
    assign opB       = cmd[CMD_USE_IMM_BIT] ? cmd[CMD_IMM_LSB +: 4] : regFile[cmdRb];
    assign acceptCmd = (state == IDLE) && cmd_valid;
    assign retireRes = (state == RESP) && res_ready;

    ALU1 uAlu (
        .inA (capA),
        .inB (capB),
        .op  (capOp),
        .ans (aluAns)
    );

    // Next-state and handshake outputs decoded from the registered state only.
    always_comb begin
        nextState = state;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) nextState = EXEC;
            end
            EXEC: nextState = RESP;
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Operand capture at accept, writeback/result load in EXEC, count on retire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            capOp    <= OP_AND;
            capDst   <= 2'd0;
            capA     <= 4'h0;
            capB     <= 4'h0;
            regFile  <= '0;
            res_data <= 4'h0;
            res_dst  <= 2'd0;
            op_count <= 8'd0;
        end else begin
            if (acceptCmd) begin
                capOp  <= aluOp_t'(cmd[CMD_OP_LSB +: 2]);
                capDst <= cmd[CMD_DST_LSB +: 2];
                capA   <= opA;
                capB   <= opB;
            end
            if (state == EXEC) begin
                if (capDst != 2'd0) regFile[capDst] <= aluAns;
                res_data <= aluAns;
                res_dst  <= capDst;
            end
            if (retireRes) op_count <= op_count + 8'd1;
        end
    end

`ifdef ALU_SEQ_CARRY_EN
    logic [4:0] sum5;
    assign sum5 = {1'b0, capA} + {1'b0, capB};

    // Carry-out of ADD, loaded and held alongside res_data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              res_carry <= 1'b0;
        else if (state == EXEC)  res_carry <= (capOp == OP_ADD) && sum5[4];
    end
`endif

endmodule
